npc_ifu: RTL and testbench

Instruction fetch unit for the npc core. It is the requester side of the single-cycle instruction-memory read port and owns the PC register. It issues one aligned 32-bit fetch per cycle, buffers fetched {pc, inst} pairs in a 2-entry FIFO, and delivers them to decode over a valid/ready handshake. It also supports branch/jump redirect with flush and a sticky halt.

---
 rtl/npc_ifu.sv | 92 +++++++++
 tb/tb_npc_ifu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/npc_ifu.sv
// Instruction fetch unit: owns the PC, issues one aligned fetch per cycle into a
// 2-entry {pc, inst} FIFO, and handles redirect-with-flush and a sticky halt.
module npc_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_ren,
  output logic [31:0] imem_raddr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  logic        flush;
  logic        pop;
  logic        fire;
  logic [31:0] redirect_target;

  // A redirect during BOOT is ignored; elsewhere it flushes and reloads the PC.
  assign flush           = redirect_valid && (state != BOOT);
  assign redirect_target = redirect_pc & ~32'h3;

  assign out_valid  = (count != 2'd0);
  assign pop        = out_valid && out_ready;
  assign fire       = (state == RUN) && !halt && !redirect_valid
                      && ((count < 2'd2) || pop);

  assign imem_ren   = fire;
  assign imem_raddr = pc;
  assign out_pc     = out_valid ? fifo_pc[head]   : 32'h0;
  assign out_inst   = out_valid ? fifo_inst[head] : 32'h0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= BOOT;
      endcase

      if (flush) begin
        pc    <= redirect_target;
        head  <= 1'b0;
        tail  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (fire) begin
          pc   <= pc + 32'd4;
          tail <= ~tail;
        end
        if (pop) head <= ~head;
        count <= count + {1'b0, fire} - {1'b0, pop};
      end
    end
  end

  // NOTE: FIFO storage has no reset; count gates every read, so stale data is never visible.
  always_ff @(posedge clock) begin
    if (fire) begin
      fifo_pc[tail]   <= pc;
      fifo_inst[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_npc_ifu.sv
// Directed bench for npc_ifu: memory echoes the fetch address as the instruction,
// so out_inst must always equal out_pc.
module tb_npc_ifu;

  logic        clock;
  logic        reset_n;
  logic        imem_ren;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int vectors = 0;
  int miscompares = 0;

  npc_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_ren       (imem_ren),
    .imem_raddr     (imem_raddr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  assign imem_rdata = imem_raddr;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow a #1 settle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    out_ready      = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // ---------------- reset / boot ----------------
    step(); #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_raddr", imem_raddr, 32'h8000_0000);
    check("rst_ren", imem_ren, 1'b0);
    check("rst_count", dut.count, 2'd0);
    reset_n = 1'b1; #1;
    check("boot_ren", imem_ren, 1'b0);
    step(); #1;
    check("c1_ren", imem_ren, 1'b1);
    check("c1_raddr", imem_raddr, 32'h8000_0000);
    check("c1_valid", out_valid, 1'b0);
    step(); #1;
    check("c2_raddr", imem_raddr, 32'h8000_0004);
    check("c2_valid", out_valid, 1'b1);
    check("c2_pc", out_pc, 32'h8000_0000);
    check("c2_inst", out_inst, 32'h8000_0000);
    step(); #1;
    check("c3_raddr", imem_raddr, 32'h8000_0008);
    check("c3_pc", out_pc, 32'h8000_0004);
    check("c3_count", dut.count, 2'd1);

    // ---------------- back-pressure ----------------
    reset_n = 1'b0; out_ready = 1'b0;
    step(); reset_n = 1'b1; #1;
    check("bp_boot_ren", imem_ren, 1'b0);
    step(); #1;
    check("bp_c1_raddr", imem_raddr, 32'h8000_0000);
    check("bp_c1_ren", imem_ren, 1'b1);
    step(); #1;
    check("bp_c2_raddr", imem_raddr, 32'h8000_0004);
    check("bp_c2_ren", imem_ren, 1'b1);
    step(); #1;
    check("bp_full_ren", imem_ren, 1'b0);
    check("bp_full_count", dut.count, 2'd2);
    check("bp_full_head", out_pc, 32'h8000_0000);
    step(); #1;
    check("bp_stall_ren", imem_ren, 1'b0);
    check("bp_stall_raddr", imem_raddr, 32'h8000_0008);
    out_ready = 1'b1; #1;
    check("bp_resume_ren", imem_ren, 1'b1);
    check("bp_resume_head", out_pc, 32'h8000_0000);
    step(); #1;
    check("bp_after_head", out_pc, 32'h8000_0004);
    check("bp_after_count", dut.count, 2'd2);
    check("bp_after_raddr", imem_raddr, 32'h8000_000C);
    step(); #1;
    check("bp_next_head", out_pc, 32'h8000_0008);

    // ---------------- redirect (pop attempted in same cycle) ----------------
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103; #1;
    check("rd_cycle_ren", imem_ren, 1'b0);
    step(); redirect_valid = 1'b0; #1;
    check("rd_n1_valid", out_valid, 1'b0);
    check("rd_n1_raddr", imem_raddr, 32'h8000_0100);
    check("rd_n1_ren", imem_ren, 1'b1);
    check("rd_n1_count", dut.count, 2'd0);
    step(); #1;
    check("rd_n2_pc", out_pc, 32'h8000_0100);
    check("rd_n2_inst", out_inst, 32'h8000_0100);
    check("rd_n2_raddr", imem_raddr, 32'h8000_0104);

    // ---------------- PC wrap-around ----------------
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    step(); redirect_valid = 1'b0; #1;
    check("wr_raddr0", imem_raddr, 32'hFFFF_FFFC);
    check("wr_valid0", out_valid, 1'b0);
    step(); #1;
    check("wr_raddr1", imem_raddr, 32'h0000_0000);
    check("wr_head0", out_pc, 32'hFFFF_FFFC);
    step(); #1;
    check("wr_head1", out_pc, 32'h0000_0000);
    check("wr_raddr2", imem_raddr, 32'h0000_0004);

    // ---------------- halt with two buffered entries ----------------
    out_ready = 1'b0; #1;
    check("ht_fill_ren", imem_ren, 1'b1);
    step(); halt = 1'b1; #1;
    check("ht_ren0", imem_ren, 1'b0);
    check("ht_count", dut.count, 2'd2);
    step(); halt = 1'b0; #1;
    check("ht_sticky_ren", imem_ren, 1'b0);
    check("ht_head0", out_pc, 32'h0000_0000);
    out_ready = 1'b1; #1;
    check("ht_drain_ren", imem_ren, 1'b0);
    step(); #1;
    check("ht_head1", out_pc, 32'h0000_0004);
    check("ht_count1", dut.count, 2'd1);
    step(); #1;
    check("ht_empty_valid", out_valid, 1'b0);
    check("ht_empty_pc", out_pc, 32'h0);
    check("ht_empty_ren", imem_ren, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; #1;
    step(); redirect_valid = 1'b0; #1;
    check("ht_rd_raddr", imem_raddr, 32'h8000_0200);
    check("ht_rd_ren", imem_ren, 1'b0);
    step(); #1;
    check("ht_rd_ren2", imem_ren, 1'b0);
    check("ht_rd_valid", out_valid, 1'b0);

    // ---------------- reset mid-run with a full FIFO ----------------
    reset_n = 1'b0; out_ready = 1'b0;
    step(); reset_n = 1'b1; #1;
    step(); #1;
    step(); #1;
    step(); #1;
    check("mr_full_count", dut.count, 2'd2);
    reset_n = 1'b0;
    step(); reset_n = 1'b1; #1;
    check("mr_valid", out_valid, 1'b0);
    check("mr_raddr", imem_raddr, 32'h8000_0000);
    check("mr_boot_ren", imem_ren, 1'b0);
    check("mr_count", dut.count, 2'd0);
    step(); #1;
    check("mr_first_ren", imem_ren, 1'b1);
    check("mr_first_raddr", imem_raddr, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
